// File: rtl/sdp_x_x_triosy_pkg.sv
// Shared definitions for the SDP multiplier-shift config / triosy completion controller.
//   - ctrl_state_e : controller FSM states (2-bit encoding)
//   - SHIFT_W_DEF  : default width of the multiplier shift-value field
//   - CNT_W_DEF    : default width of the pending-completion counter
package sdp_x_x_triosy_pkg;

  localparam int unsigned SHIFT_W_DEF = 6;
  localparam int unsigned CNT_W_DEF   = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StDone   = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/sdp_x_x_triosy_pend_cnt.sv
// Saturating pending-completion counter with sticky overflow flag.
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - synchronous active-low reset
//   inc_i    - one new pending transaction
//   dec_i    - one transaction completed
//   cnt_o    - current pending count
//   ovf_o    - sticky: an increment arrived while the counter was full
module sdp_x_x_triosy_pend_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             ovf_d, ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    // Simultaneous inc and dec cancel out.
    if (inc_i && !dec_i) begin
      if (cnt_q == CntMax) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/sdp_x_x_cfg_mul_shift_triosy_ctrl.sv
// Holds the SDP multiplier shift value for the core datapath and tracks triosy completions.
// Ports:
//   nvdla_core_clk / nvdla_core_rstn     - clock, synchronous active-low reset
//   cfg_vld / cfg_rdy / cfg_mul_shift_value_in - config handshake and offered value
//   cfg_mul_shift_value_out / _vld       - held value and its valid flag
//   core_wen / core_wten                 - core stage enable / stall
//   oswt                                 - core request for one triosy transaction
//   obj_bawt                             - downstream transaction-available flag
//   obj_biwt / obj_bdwt                  - input-wait / done-wait strobes to downstream
//   triosy_lz                            - completion pulse to the triosy object
//   ovf_err                              - sticky pending-counter overflow
module sdp_x_x_cfg_mul_shift_triosy_ctrl
  import sdp_x_x_triosy_pkg::*;
#(
  parameter int unsigned SHIFT_W = SHIFT_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rstn,
  input  logic               cfg_vld,
  output logic               cfg_rdy,
  input  logic [SHIFT_W-1:0] cfg_mul_shift_value_in,
  output logic [SHIFT_W-1:0] cfg_mul_shift_value_out,
  output logic               cfg_mul_shift_value_vld,
  input  logic               core_wen,
  input  logic               core_wten,
  input  logic               oswt,
  input  logic               obj_bawt,
  output logic               obj_biwt,
  output logic               obj_bdwt,
  output logic               triosy_lz,
  output logic               ovf_err
);

  ctrl_state_e        state_d, state_q;
  logic [SHIFT_W-1:0] held_d, held_q;
  logic [CNT_W-1:0]   pend_cnt;
  logic               in_done;
  logic               pend_inc;
  logic               accept;

  assign in_done  = (state_q == StDone);
  assign pend_inc = oswt && (state_q != StIdle);
  assign accept   = in_done && obj_bawt && core_wen;

  sdp_x_x_triosy_pend_cnt #(
    .CNT_W (CNT_W)
  ) u_pend_cnt (
    .clk_i  (nvdla_core_clk),
    .rst_ni (nvdla_core_rstn),
    .inc_i  (pend_inc),
    .dec_i  (accept),
    .cnt_o  (pend_cnt),
    .ovf_o  (ovf_err)
  );

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_vld) begin
          held_d  = cfg_mul_shift_value_in;
          state_d = StActive;
        end
      end
      StActive: begin
        if (pend_cnt != '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Last outstanding completion drains; held value is kept for the next user.
        if (accept && !pend_inc && (pend_cnt == CNT_W'(1))) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state_q <= StIdle;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  assign cfg_rdy                 = (state_q == StIdle);
  assign cfg_mul_shift_value_vld = (state_q != StIdle);
  assign cfg_mul_shift_value_out = held_q;
  assign obj_biwt                = in_done && core_wen;
  assign obj_bdwt                = in_done && core_wten;
  assign triosy_lz               = accept;

endmodule
